// File: rtl/regfile_sequencer.sv
// regfile_sequencer: control FSM that walks the RNBIP-2 8x8 register file through
// the per-instruction control sequence, including the read -> ALU -> write-back trip.
module regfile_sequencer #(
  parameter int ALU_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       instr_valid,
  input  logic [2:0] instr_op,
  input  logic [2:0] instr_rn,
  output logic       instr_ready,
  input  logic       alu_done,
  output logic       alu_start,
  output logic [1:0] enab,
  output logic [2:0] mux_sel,
  output logic [2:0] reg_sel,
  output logic [2:0] seg,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_CLR   = 3'd1,
    OP_MOVR0 = 3'd2,
    OP_MOVRN = 3'd3,
    OP_LDI   = 3'd4,
    OP_ALU   = 3'd5,
    OP_CMP   = 3'd6,
    OP_ILL   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WRITE,
    S_READ,
    S_ALU_WAIT,
    S_ALU_WB,
    S_DONE
  } state_e;

  localparam logic [7:0] TIMEOUT_CNT = 8'(ALU_TIMEOUT);

  state_e     state, state_nxt;
  op_e        op_q;
  logic [2:0] rn_q;
  logic [7:0] cnt;
  logic       ready_en;
  logic       err_set;
  logic       accept;

  // ready_en holds instr_ready low until the first edge after reset release
  assign instr_ready = (state == S_IDLE) && ready_en;
  assign busy        = (state != S_IDLE);
  assign accept      = instr_valid && instr_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      op_q     <= OP_NOP;
      rn_q     <= 3'd0;
      cnt      <= 8'd0;
      ready_en <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      if (err_set)
        err <= 1'b1;
      if (accept) begin
        op_q <= op_e'(instr_op);
        rn_q <= instr_rn;
      end
      if (state == S_ALU_WAIT && state_nxt == S_ALU_WAIT)
        cnt <= cnt + 8'd1;
      else
        cnt <= 8'd0;
    end
  end

  // In ALU_WAIT, cnt==0 marks the alu_start cycle, where alu_done is ignored;
  // alu_done is tested before the timeout so it wins when both coincide.
  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          case (op_e'(instr_op))
            OP_NOP:                     state_nxt = S_DONE;
            OP_CLR:                     state_nxt = S_CLEAR;
            OP_MOVR0, OP_MOVRN, OP_LDI: state_nxt = S_WRITE;
            OP_ALU, OP_CMP:             state_nxt = S_READ;
            default: begin
              err_set   = 1'b1;
              state_nxt = S_DONE;
            end
          endcase
        end
      end
      S_CLEAR, S_WRITE, S_ALU_WB: state_nxt = S_DONE;
      S_READ:                     state_nxt = S_ALU_WAIT;
      S_ALU_WAIT: begin
        if (cnt != 8'd0 && alu_done) begin
          state_nxt = (op_q == OP_ALU) ? S_ALU_WB : S_DONE;
        end else if (cnt == TIMEOUT_CNT) begin
          err_set   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    enab      = 2'b10;
    mux_sel   = 3'b000;
    reg_sel   = 3'b000;
    seg       = 3'b000;
    alu_start = 1'b0;
    done      = 1'b0;
    case (state)
      S_CLEAR: enab = 2'b00;
      S_WRITE: begin
        enab = 2'b01;
        case (op_q)
          OP_MOVR0: seg = rn_q;
          OP_MOVRN: begin
            mux_sel = 3'b001;
            reg_sel = rn_q;
          end
          OP_LDI: begin
            mux_sel = 3'b010;
            seg     = rn_q;
          end
          default: ;
        endcase
      end
      S_READ: begin
        enab = 2'b11;
        seg  = rn_q;
      end
      S_ALU_WAIT: alu_start = (cnt == 8'd0);
      S_ALU_WB: begin
        enab    = 2'b01;
        mux_sel = 3'b011;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: randomized self-checking bench; a per-opcode cycle script
// model predicts every output on every cycle.
module tb_regfile_sequencer;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       instr_valid;
  logic [2:0] instr_op;
  logic [2:0] instr_rn;
  logic       instr_ready;
  logic       alu_done;
  logic       alu_start;
  logic [1:0] enab;
  logic [2:0] mux_sel;
  logic [2:0] reg_sel;
  logic [2:0] seg;
  logic       busy;
  logic       done;
  logic       err;

  regfile_sequencer #(.ALU_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_op(instr_op),
    .instr_rn(instr_rn), .instr_ready(instr_ready), .alu_done(alu_done),
    .alu_start(alu_start), .enab(enab), .mux_sel(mux_sel), .reg_sel(reg_sel),
    .seg(seg), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // One expected cycle: outputs, whether err becomes set, alu_done to drive
  typedef struct {
    bit       rdy;
    bit       bsy;
    bit [1:0] en;
    bit [2:0] mux;
    bit [2:0] rsel;
    bit [2:0] sg;
    bit       st;
    bit       dn;
    bit       eset;
    bit       ad;
    bit       waitc;
  } ent_t;

  typedef struct {
    bit [2:0] op;
    bit [2:0] rn;
    int       d;
    int       lat;
    bit       lerr;
    bit       rst;
  } dir_t;

  ent_t script[$];
  dir_t plan[$];
  ent_t exp_cur, exp_nxt;
  bit   m_err;
  int   vectors, miscompares, cyc;
  bit   reset_armed, lat_pend, lerr_exp;
  int   lat_exp, acc_cyc;

  function automatic ent_t idle_ent(bit rdy);
    ent_t e;
    e.rdy = rdy; e.bsy = 1'b0; e.en = 2'b10; e.mux = 3'd0; e.rsel = 3'd0; e.sg = 3'd0;
    e.st = 1'b0; e.dn = 1'b0; e.eset = 1'b0; e.waitc = 1'b0;
    e.ad = 1'($urandom_range(0, 1));
    return e;
  endfunction

  function automatic ent_t busy_ent();
    ent_t e = idle_ent(1'b0);
    e.bsy = 1'b1;
    return e;
  endfunction

  // d = cycles from alu_start to alu_done; d = 0 means alu_done never comes
  function automatic void build(bit [2:0] op, bit [2:0] rn, int d);
    ent_t e;
    case (op)
      3'b001: begin e = busy_ent(); e.en = 2'b00; script.push_back(e); end
      3'b010: begin e = busy_ent(); e.en = 2'b01; e.sg = rn; script.push_back(e); end
      3'b011: begin e = busy_ent(); e.en = 2'b01; e.mux = 3'b001; e.rsel = rn; script.push_back(e); end
      3'b100: begin e = busy_ent(); e.en = 2'b01; e.mux = 3'b010; e.sg = rn; script.push_back(e); end
      3'b101, 3'b110: begin
        e = busy_ent(); e.en = 2'b11; e.sg = rn; script.push_back(e);
        e = busy_ent(); e.st = 1'b1; script.push_back(e);
        if (d > 0) begin
          for (int i = 1; i <= d; i++) begin
            e = busy_ent(); e.waitc = 1'b1; e.ad = (i == d); script.push_back(e);
          end
          if (op == 3'b101) begin
            e = busy_ent(); e.en = 2'b01; e.mux = 3'b011; script.push_back(e);
          end
        end else begin
          for (int i = 1; i <= TMO; i++) begin
            e = busy_ent(); e.waitc = 1'b1; e.ad = 1'b0; script.push_back(e);
          end
        end
      end
      default: ;
    endcase
    e = busy_ent();
    e.dn = 1'b1;
    e.eset = (op == 3'b111) || ((op == 3'b101 || op == 3'b110) && d == 0);
    script.push_back(e);
  endfunction

  task automatic checkOutput(input ent_t e, input bit eerr, input string name);
    logic [16:0] act, want;
    act  = {instr_ready, busy, enab, mux_sel, reg_sel, seg, alu_start, done, err};
    want = {e.rdy, e.bsy, e.en, e.mux, e.rsel, e.sg, e.st, e.dn, eerr};
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: actual %b required %b", name, cyc, act, want);
    end
  endtask

  task automatic checkResetLit(input string name);
    logic [16:0] act, want;
    want = 17'b0_0_10_000_000_000_0_0_0;
    act  = {instr_ready, busy, enab, mux_sel, reg_sel, seg, alu_start, done, err};
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %b required %b", name, act, want);
    end
  endtask

  task automatic doReset();
    #2 reset_n = 1'b0;
    instr_valid = 1'b1;
    #1;
    m_err = 1'b0;
    script.delete();
    lat_pend = 1'b0;
    reset_armed = 1'b0;
    checkResetLit("reset_assert");
    @(negedge clk);
    cyc++;
    checkResetLit("reset_held");
    reset_n = 1'b1;
    exp_cur = idle_ent(1'b0);
  endtask

  task automatic applyStimulus();
    dir_t di;
    bit   take;
    checkOutput(exp_cur, m_err, "cycle");
    if (lat_pend && (done === 1'b1 || cyc - acc_cyc > 60)) begin
      vectors++;
      if (done !== 1'b1 || cyc - acc_cyc != lat_exp || err !== lerr_exp) begin
        miscompares++;
        $display("[TB] FAIL latency: actual lat %0d done %b err %b required lat %0d err %b",
                 cyc - acc_cyc, done, err, lat_exp, lerr_exp);
      end
      lat_pend = 1'b0;
    end
    if (reset_armed && exp_cur.waitc) begin
      doReset();
      return;
    end
    take = 1'b0;
    alu_done = exp_cur.ad;
    instr_op = 3'($urandom_range(0, 7));
    instr_rn = 3'($urandom_range(0, 7));
    if (instr_op == 3'b111 && $urandom_range(0, 3) != 0)
      instr_op = 3'b101;
    if (exp_cur.rdy && plan.size() > 0) begin
      di = plan.pop_front();
      take = 1'b1;
      instr_valid = 1'b1;
      instr_op = di.op;
      instr_rn = di.rn;
    end else if (plan.size() > 0 || lat_pend) begin
      instr_valid = 1'b1;
    end else begin
      instr_valid = ($urandom_range(0, 9) < 7);
    end
    if (exp_cur.rdy && instr_valid) begin
      int d;
      if (take) d = di.d;
      else d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TMO));
      build(instr_op, instr_rn, d);
      if (take) begin
        if (di.lat > 0) begin
          lat_pend = 1'b1;
          lat_exp  = di.lat;
          lerr_exp = di.lerr;
          acc_cyc  = cyc;
        end
        reset_armed = di.rst;
      end
    end
    exp_nxt = (script.size() > 0) ? script.pop_front() : idle_ent(1'b1);
    @(negedge clk);
    cyc++;
    exp_cur = exp_nxt;
    if (exp_cur.eset) m_err = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; instr_valid = 1'b1; instr_op = 3'd0; instr_rn = 3'd0; alu_done = 1'b0;
    m_err = 1'b0; vectors = 0; miscompares = 0; cyc = 0;
    reset_armed = 1'b0; lat_pend = 1'b0; lerr_exp = 1'b0; lat_exp = 0; acc_cyc = 0;
    #3 checkResetLit("reset_initial");
    @(negedge clk);
    checkResetLit("reset_initial_held");
    reset_n = 1'b1;
    instr_valid = 1'b0;
    exp_cur = idle_ent(1'b0);

    plan.push_back('{3'b100, 3'd5, 0, 2, 1'b0, 1'b0});
    plan.push_back('{3'b011, 3'd3, 0, 2, 1'b0, 1'b0});
    plan.push_back('{3'b101, 3'd2, 3, 7, 1'b0, 1'b0});
    plan.push_back('{3'b001, 3'd0, 0, 2, 1'b0, 1'b0});
    plan.push_back('{3'b010, 3'd6, 0, 2, 1'b0, 1'b0});
    plan.push_back('{3'b110, 3'd4, 2, 5, 1'b0, 1'b0});
    plan.push_back('{3'b101, 3'd1, TMO, 8, 1'b0, 1'b0});
    plan.push_back('{3'b101, 3'd7, 0, 7, 1'b1, 1'b0});
    plan.push_back('{3'b000, 3'd0, 0, 1, 1'b1, 1'b0});
    for (int i = 0; i < 400 && (plan.size() > 0 || lat_pend); i++) applyStimulus();
    for (int i = 0; i < 600; i++) applyStimulus();

    plan.push_back('{3'b101, 3'd1, 0, 0, 1'b0, 1'b1});
    plan.push_back('{3'b111, 3'd0, 0, 1, 1'b1, 1'b0});
    plan.push_back('{3'b001, 3'd0, 0, 2, 1'b1, 1'b0});
    for (int i = 0; i < 400 && (plan.size() > 0 || lat_pend); i++) applyStimulus();
    for (int i = 0; i < 600; i++) applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Control FSM for the RNBIP-2 8×8 register file. Accepts one decoded register-class instruction at a time over a valid/ready handshake. Drives the register file's `enab`, `mux_sel`, `reg_sel` and `seg` controls through the correct multi-cycle sequence for each instruction, including the read → ALU → write-back round trip. Sits between the instruction decoder and the register file/ALU pair.

## Interface
Parameters:
- `ALU_TIMEOUT`, default 15: maximum number of cycles to wait for `alu_done` after `alu_start`. Legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `instr_valid`  in  1  decoder presents an instruction.
- `instr_op`  in  3  opcode (encodings under Operation).
- `instr_rn`  in  3  register index Rn.
- `instr_ready`  out  1  sequencer can accept; high only in IDLE.
- `alu_done`  in  1  ALU result is valid on the register file's `ALU_IN` input.
- `alu_start`  out  1  one-cycle ALU launch pulse.
- `enab`  out  2  register file mode: 00 clear, 01 write, 11 read, 10 no-op.
- `mux_sel`  out  3  write source: 000 R0, 001 Rn, 010 OR2, 011 ALU.
- `reg_sel`  out  3  source register index for `mux_sel`=001.
- `seg`  out  3  target register index for write or read port B.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at instruction completion.
- `err`  out  1  sticky error flag; cleared only by reset.

## Operation
- Handshake: an instruction is accepted on the rising edge where `instr_valid` and `instr_ready` are both high. `instr_op` and `instr_rn` are latched at that edge and do not need to be held afterwards.
- Opcodes:
  - 000 NOP → DONE.
  - 001 CLR → CLEAR.
  - 010 MOVR0 (Rn←R0) → WRITE with mux_sel=000, seg=Rn.
  - 011 MOVRN (R0←Rn) → WRITE with mux_sel=001, reg_sel=Rn, seg=0.
  - 100 LDI (Rn←OR2) → WRITE with mux_sel=010, seg=Rn.
  - 101 ALU → READ → ALU_WAIT → ALU_WB → DONE.
  - 110 CMP → READ → ALU_WAIT → DONE; no write-back.
  - 111 illegal → set `err`, → DONE.
- States and outputs (any output not listed takes its idle value):
  - IDLE: `instr_ready`=1, `enab`=10.
  - CLEAR: `enab`=00 for one cycle.
  - WRITE: `enab`=01 with the selects above, for one cycle.
  - READ: `enab`=11, seg=Rn, for one cycle.
  - ALU_WAIT: `enab`=10; `alu_start`=1 in the first cycle only.
  - ALU_WB: `enab`=01, mux_sel=011, seg=000, for one cycle.
  - DONE: `done`=1, `enab`=10, for one cycle, then → IDLE.
- ALU_WAIT exit rules:
  - `alu_done` is ignored in the `alu_start` cycle.
  - A 8-bit counter clears on entry and increments each following cycle.
  - `alu_done` high on a sampled edge → next state (ALU_WB or DONE).
  - Timeout: counter reaches `ALU_TIMEOUT` with no `alu_done` → set `err`, → DONE. No write-back occurs on timeout.
  - If `alu_done` and the timeout condition coincide, `alu_done` wins; no error is flagged.
- Idle output values: `enab`=10, `mux_sel`=000, `reg_sel`=000, `seg`=000, `alu_start`=0, `done`=0.
- Reset:
  - All outputs take their idle values immediately on reset assertion, except `instr_ready`=0 and `busy`=0 while `reset_n`=0.
  - The FSM enters IDLE; `err` and the counter clear.
  - Reset mid-instruction abandons it with no further register-file actions; the instruction is not completed.
  - `instr_ready` rises on the first cycle after reset release.

## Timing
- All outputs are registered or decoded from the state register only; there is no combinational path from inputs to outputs.
- `instr_valid` is ignored while busy. Back-to-back throughput is limited because `instr_ready` is low from the accept edge until DONE has completed.
- Latency from the accept edge (edge 0) to the `done` cycle:
  - NOP and illegal: `done` high in cycle 1.
  - CLR, MOV, LDI: action in cycle 1, `done` in cycle 2.
  - ALU with `alu_done` asserted d cycles after `alu_start` (d ≥ 1): READ in cycle 1, `alu_start` in cycle 2, `alu_done` seen at cycle 2+d, ALU_WB in cycle 3+d, `done` in cycle 4+d.
  - CMP: `done` in cycle 3+d.
- The earliest next accept is the edge ending the first IDLE cycle after DONE.

## Test plan
- Reset, then LDI with Rn=5 → `enab`=01, `mux_sel`=010, `seg`=101 for exactly one cycle; `done` one cycle later; `instr_ready` back high after that.
- MOVRN with Rn=3 → `reg_sel`=011, `seg`=000, `mux_sel`=001; `instr_valid` held high through the busy window → no second accept until IDLE.
- ALU with Rn=2, bench asserts `alu_done` 3 cycles after `alu_start` → READ `seg`=010, single `alu_start` pulse, ALU_WB (`mux_sel`=011, `seg`=000), `done` at cycle 7, `err`=0.
- ALU with `ALU_TIMEOUT`=4 and `alu_done` never asserted → `err`=1, no ALU_WB cycle, `done` pulse; `err` stays high through a following NOP.
- Opcode 111 → `err`=1, `done` in cycle 1, `enab` stays 10 throughout; CLR → `enab`=00 for one cycle.
- Assert `reset_n` low during ALU_WAIT → outputs go to idle values immediately; no ALU_WB after release; `instr_ready`=1 on the first cycle after release.
